// File: rtl/reg_wb_if.sv
// Writeback bus between the two requesters, the clear control and the register file write port.
// The slave modport is the arbiter's view; master is the requester/register-file side.
interface reg_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_src;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_start,
    output a_ready, b_ready, clr_busy, clr_done, wr_en, wr_addr, wr_data, wr_src
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_start,
    input  a_ready, b_ready, clr_busy, clr_done, wr_en, wr_addr, wr_data, wr_src
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between A (EX) and B (load),
// plus a soft-clear sequence that zeroes r1..NREG-1 through the same port.
module reg_wb_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic     clk,
  input  logic     rst,
  reg_wb_if.slave  bus
);
  localparam int CW = $clog2(NREG);
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_A    = 2'b01;
  localparam logic [1:0] SRC_B    = 2'b10;
  localparam logic [1:0] SRC_CLR  = 2'b11;

  typedef enum logic { S_ARB, S_CLEAR } state_e;
  typedef enum logic { RR_A, RR_B } rr_e;

  state_e        state_q, state_d;
  rr_e           rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [1:0]    wr_src_q, wr_src_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          grant_a, grant_b;

  // NOTE: every always_comb output gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = SRC_NONE;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;

    case (state_q)
      S_ARB: begin
        if (bus.clr_start) begin
          // Clear wins over any request presented in the same cycle.
          state_d   = S_CLEAR;
          cnt_d     = CW'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = AW'(cnt_d);
          wr_data_d = '0;
          wr_src_d  = SRC_CLR;
          busy_d    = 1'b1;
          done_d    = (cnt_d == CW'(NREG - 1));
        end else if (bus.a_valid && (!bus.b_valid || rr_q == RR_A)) begin
          grant_a   = 1'b1;
          rr_d      = RR_B;
          wr_en_d   = (bus.a_addr != '0);
          wr_addr_d = bus.a_addr;
          wr_data_d = bus.a_data;
          wr_src_d  = SRC_A;
        end else if (bus.b_valid) begin
          grant_b   = 1'b1;
          rr_d      = RR_A;
          wr_en_d   = (bus.b_addr != '0);
          wr_addr_d = bus.b_addr;
          wr_data_d = bus.b_data;
          wr_src_d  = SRC_B;
        end
      end
      S_CLEAR: begin
        // The register outputs already show cnt_q; load the next address or finish.
        if (cnt_q == CW'(NREG - 1)) begin
          state_d = S_ARB;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = AW'(cnt_d);
          wr_data_d = '0;
          wr_src_d  = SRC_CLR;
          busy_d    = 1'b1;
          done_d    = (cnt_d == CW'(NREG - 1));
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ARB;
      rr_q      <= RR_A;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= SRC_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Readies are forced low while reset is held, independent of the clock.
  assign bus.a_ready  = grant_a & ~rst;
  assign bus.b_ready  = grant_b & ~rst;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_src   = wr_src_q;
  assign bus.clr_busy = busy_q;
  assign bus.clr_done = done_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: a vector table for arbitration/writeback plus
// hand-written sequences for reset, contention from reset, and the soft clear.
module tb_reg_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  reg_wb_if #(.DW(DW), .AW(AW)) bus ();

  reg_wb_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          a_v;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_v;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          exp_a_rdy;
    logic          exp_b_rdy;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_src;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a_v, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data,
                       input logic b_v, input logic [AW-1:0] b_addr, input logic [DW-1:0] b_data,
                       input logic clr);
    bus.a_valid   = a_v;
    bus.a_addr    = a_addr;
    bus.a_data    = a_data;
    bus.b_valid   = b_v;
    bus.b_addr    = b_addr;
    bus.b_data    = b_data;
    bus.clr_start = clr;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [1:0] src);
    check({tag, " wr_en"},   64'(bus.wr_en),   64'(en));
    check({tag, " wr_addr"}, 64'(bus.wr_addr), 64'(addr));
    check({tag, " wr_data"}, 64'(bus.wr_data), 64'(data));
    check({tag, " wr_src"},  64'(bus.wr_src),  64'(src));
  endtask

  initial begin
    // Readies reflect this cycle's inputs; wr_* reflect the previous cycle's transfer.
    // After reset rr=A.
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        2'b00};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        2'b00};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 2'b01};
    vecs[3]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 2'b00};
    vecs[4]  = '{1'b1, 5'd3,  32'h11,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd4,  32'h22,       2'b10};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 5'd3,  32'h11,       2'b01};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 2'b10};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 2'b00};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'h12345678, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 2'b00};
    vecs[9]  = '{1'b1, 5'd7,  32'hA5,       1'b1, 5'd8,  32'h5A,       1'b1, 1'b0, 1'b1, 5'd31, 32'h12345678, 2'b10};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h5A,       1'b0, 1'b1, 1'b1, 5'd7,  32'hA5,       2'b01};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd8,  32'h5A,       2'b10};

    drive(1'b1, 5'd2, 32'h77, 1'b1, 5'd9, 32'h88, 1'b0);
    #2;
    check("reset a_ready", 64'(bus.a_ready), 64'd0);
    check("reset b_ready", 64'(bus.b_ready), 64'd0);
    check("reset clr_busy", 64'(bus.clr_busy), 64'd0);
    check("reset clr_done", 64'(bus.clr_done), 64'd0);
    check_wr("reset", 1'b0, 5'd0, 32'h0, 2'b00);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].a_v, vecs[i].a_addr, vecs[i].a_data,
            vecs[i].b_v, vecs[i].b_addr, vecs[i].b_data, 1'b0);
      #1;
      check($sformatf("vec%0d a_ready", i), 64'(bus.a_ready), 64'(vecs[i].exp_a_rdy));
      check($sformatf("vec%0d b_ready", i), 64'(bus.b_ready), 64'(vecs[i].exp_b_rdy));
      check_wr($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_addr,
               vecs[i].exp_data, vecs[i].exp_src);
    end

    // Reset mid-stream with A valid, then contention from reset: A must win first.
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("pre-reset a_ready", 64'(bus.a_ready), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst a_ready", 64'(bus.a_ready), 64'd0);
    check("midrst wr_en", 64'(bus.wr_en), 64'd0);
    check("midrst wr_src", 64'(bus.wr_src), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
    #1;
    check("cont c0 a_ready", 64'(bus.a_ready), 64'd1);
    check("cont c0 b_ready", 64'(bus.b_ready), 64'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h22, 1'b0);
    #1;
    check("cont c1 b_ready", 64'(bus.b_ready), 64'd1);
    check_wr("cont c1", 1'b1, 5'd3, 32'h11, 2'b01);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check_wr("cont c2", 1'b1, 5'd4, 32'h22, 2'b10);

    // Clear colliding with an A request; a second clr_start mid-clear must be ignored.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    check("clr t a_ready", 64'(bus.a_ready), 64'd0);
    check("clr t b_ready", 64'(bus.b_ready), 64'd0);
    for (int k = 1; k < NREG; k++) begin
      @(negedge clk);
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, k == 5);
      #1;
      check_wr($sformatf("clr t+%0d", k), 1'b1, AW'(k), 32'h0, 2'b11);
      check($sformatf("clr t+%0d busy", k), 64'(bus.clr_busy), 64'd1);
      check($sformatf("clr t+%0d done", k), 64'(bus.clr_done), 64'(k == NREG - 1));
      check($sformatf("clr t+%0d a_ready", k), 64'(bus.a_ready), 64'd0);
    end
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("clr t+32 a_ready", 64'(bus.a_ready), 64'd1);
    check("clr t+32 busy", 64'(bus.clr_busy), 64'd0);
    check("clr t+32 done", 64'(bus.clr_done), 64'd0);
    check_wr("clr t+32", 1'b0, 5'd31, 32'h0, 2'b00);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check_wr("clr t+33", 1'b1, 5'd9, 32'h99, 2'b01);

    // Reset while the clear is writing address 10 aborts the sequence.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    end
    #1;
    check("rstclr pre addr", 64'(bus.wr_addr), 64'd10);
    rst = 1'b1;
    #1;
    check("rstclr busy", 64'(bus.clr_busy), 64'd0);
    check("rstclr wr_en", 64'(bus.wr_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rstclr %0d wr_en", k), 64'(bus.wr_en), 64'd0);
      check($sformatf("post-rstclr %0d wr_src", k), 64'(bus.wr_src), 64'd0);
      check($sformatf("post-rstclr %0d busy", k), 64'(bus.clr_busy), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
